// File: rtl/dragonfang_pkg.sv
// ============================================================================
// dragonfang_pkg: shared types and constants for the dragonfang operand stage.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package dragonfang_pkg;

    localparam int DF_DATA_WIDTH = 64;
    localparam int DF_NUM_VREGS  = 32;
    localparam int DF_AW         = $clog2(DF_NUM_VREGS);

    localparam logic [DF_AW-1:0] V0_INDEX = '0;

    typedef struct packed {
        logic [5:0] funct6;
        logic [2:0] funct3;
        logic [2:0] vsew;
        logic       vm;
    } execution_vector_t;

    // hit bits are ordered {vd, vs1, vs2, v0}
    typedef struct packed {
        logic [3:0]               hit;
        logic [DF_DATA_WIDTH-1:0] vd;
        logic [DF_DATA_WIDTH-1:0] vs1;
        logic [DF_DATA_WIDTH-1:0] vs2;
        logic [DF_DATA_WIDTH-1:0] v0;
    } operand_bundle_t;

    typedef struct packed {
        logic                     valid;
        logic [DF_AW-1:0]         addr;
        logic [DF_DATA_WIDTH-1:0] data;
    } bypass_entry_t;

endpackage

`default_nettype wire

// File: rtl/dragonfang_rr_arbiter.sv
// ============================================================================
// dragonfang_rr_arbiter: round-robin one-hot grant, pointer moves past winner.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dragonfang_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_q) + k) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
        ptr_d = any_o ? IW'((int'(idx_o) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dragonfang_operand_bypass_unit.sv
// ============================================================================
// dragonfang_operand_bypass_unit: operand collection with result forwarding.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dragonfang_operand_bypass_unit
    import dragonfang_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_FU     = 4,
    parameter int NUM_VREGS  = 32,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(NUM_VREGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  execution_vector_t            in_execution_vector,
    input  logic [AW-1:0]                in_vs2_addr,
    input  logic [AW-1:0]                in_vs1_addr,
    input  logic [AW-1:0]                in_vd_addr,
    input  logic [DATA_WIDTH-1:0]        in_v0_data,
    input  logic [DATA_WIDTH-1:0]        in_vs2_data,
    input  logic [DATA_WIDTH-1:0]        in_vs1_data,
    input  logic [DATA_WIDTH-1:0]        in_vd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output execution_vector_t            out_execution_vector,
    output logic [DATA_WIDTH-1:0]        out_v0,
    output logic [DATA_WIDTH-1:0]        out_vs2,
    output logic [DATA_WIDTH-1:0]        out_vs1,
    output logic [DATA_WIDTH-1:0]        out_vd,
    output logic [3:0]                   out_bypass_hit,
    input  logic [NUM_FU-1:0]            wb_valid,
    output logic [NUM_FU-1:0]            wb_ready,
    input  logic [NUM_FU*AW-1:0]         wb_addr,
    input  logic [NUM_FU*DATA_WIDTH-1:0] wb_data,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int GW = $clog2(NUM_FU);

    // Packed types come from the package, so DATA_WIDTH/NUM_VREGS must match it.
    bypass_entry_t             buf_q [DEPTH];
    logic [PW-1:0]             wr_ptr_q;
    logic                      rf_we_q;
    logic [AW-1:0]             rf_waddr_q;
    logic [DATA_WIDTH-1:0]     rf_wdata_q;
    logic                      out_valid_q;
    logic                      out_valid_d;
    execution_vector_t         exec_q;
    operand_bundle_t           bundle_q;
    operand_bundle_t           bundle_d;

    logic [GW-1:0]             w_gnt_idx;
    logic                      w_gnt_any;
    logic [AW-1:0]             w_gnt_addr;
    logic [DATA_WIDTH-1:0]     w_gnt_data;
    logic                      w_issue;
    logic [DATA_WIDTH:0]       w_res_v0;
    logic [DATA_WIDTH:0]       w_res_vs2;
    logic [DATA_WIDTH:0]       w_res_vs1;
    logic [DATA_WIDTH:0]       w_res_vd;

    dragonfang_rr_arbiter #(
        .N  (NUM_FU),
        .IW (GW)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .req_i (wb_valid),
        .gnt_o (wb_ready),
        .idx_o (w_gnt_idx),
        .any_o (w_gnt_any)
    );

    assign w_gnt_addr = wb_addr[int'(w_gnt_idx)*AW +: AW];
    assign w_gnt_data = wb_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Returns {hit, data}. Walks oldest->newest so the newest match wins,
    // then lets this cycle's granted result override everything.
    function automatic logic [DATA_WIDTH:0] resolve(
        input logic [AW-1:0]         addr,
        input logic [DATA_WIDTH-1:0] rf_data,
        input bypass_entry_t         ents [DEPTH],
        input logic [PW-1:0]         wptr,
        input logic                  g_any,
        input logic [AW-1:0]         g_addr,
        input logic [DATA_WIDTH-1:0] g_data
    );
        logic [DATA_WIDTH:0] r;
        logic [PW-1:0]       idx;
        r = {1'b0, rf_data};
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wptr - PW'(k);
            if (ents[idx].valid && ents[idx].addr == addr) begin
                r = {1'b1, ents[idx].data};
            end
        end
        if (g_any && g_addr == addr) begin
            r = {1'b1, g_data};
        end
        return r;
    endfunction

    assign w_res_v0  = resolve(V0_INDEX,    in_v0_data,  buf_q, wr_ptr_q, w_gnt_any, w_gnt_addr, w_gnt_data);
    assign w_res_vs2 = resolve(in_vs2_addr, in_vs2_data, buf_q, wr_ptr_q, w_gnt_any, w_gnt_addr, w_gnt_data);
    assign w_res_vs1 = resolve(in_vs1_addr, in_vs1_data, buf_q, wr_ptr_q, w_gnt_any, w_gnt_addr, w_gnt_data);
    assign w_res_vd  = resolve(in_vd_addr,  in_vd_data,  buf_q, wr_ptr_q, w_gnt_any, w_gnt_addr, w_gnt_data);

    assign in_ready = !out_valid_q || out_ready;
    assign w_issue  = in_valid && in_ready;

    always_comb begin
        bundle_d     = bundle_q;
        out_valid_d  = out_valid_q;
        if (w_issue) begin
            bundle_d.v0  = w_res_v0[DATA_WIDTH-1:0];
            bundle_d.vs2 = w_res_vs2[DATA_WIDTH-1:0];
            bundle_d.vs1 = w_res_vs1[DATA_WIDTH-1:0];
            bundle_d.vd  = w_res_vd[DATA_WIDTH-1:0];
            bundle_d.hit = {w_res_vd[DATA_WIDTH], w_res_vs1[DATA_WIDTH],
                            w_res_vs2[DATA_WIDTH], w_res_v0[DATA_WIDTH]};
            out_valid_d  = 1'b1;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            exec_q      <= '0;
            bundle_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            if (w_issue) begin
                exec_q <= in_execution_vector;
            end
        end
    end

    // Writeback is independent of issue stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            rf_we_q <= w_gnt_any;
            if (w_gnt_any) begin
                rf_waddr_q      <= w_gnt_addr;
                rf_wdata_q      <= w_gnt_data;
                buf_q[wr_ptr_q] <= '{valid: 1'b1, addr: w_gnt_addr, data: w_gnt_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
        end
    end

    assign out_valid            = out_valid_q;
    assign out_execution_vector = exec_q;
    assign out_v0               = bundle_q.v0;
    assign out_vs2              = bundle_q.vs2;
    assign out_vs1              = bundle_q.vs1;
    assign out_vd               = bundle_q.vd;
    assign out_bypass_hit       = bundle_q.hit;
    assign rf_we                = rf_we_q;
    assign rf_waddr             = rf_waddr_q;
    assign rf_wdata             = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dragonfang_operand_bypass_unit.sv
// ============================================================================
// tb_dragonfang_operand_bypass_unit: directed self-checking bench.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dragonfang_operand_bypass_unit;
    import dragonfang_pkg::*;

    localparam int DW  = 64;
    localparam int NFU = 4;
    localparam int AW  = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    execution_vector_t      in_execution_vector;
    logic [AW-1:0]          in_vs2_addr, in_vs1_addr, in_vd_addr;
    logic [DW-1:0]          in_v0_data, in_vs2_data, in_vs1_data, in_vd_data;
    logic                   out_valid;
    logic                   out_ready;
    execution_vector_t      out_execution_vector;
    logic [DW-1:0]          out_v0, out_vs2, out_vs1, out_vd;
    logic [3:0]             out_bypass_hit;
    logic [NFU-1:0]         wb_valid;
    logic [NFU-1:0]         wb_ready;
    logic [NFU*AW-1:0]      wb_addr;
    logic [NFU*DW-1:0]      wb_data;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DW-1:0]          rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    dragonfang_operand_bypass_unit #(
        .DATA_WIDTH (DW),
        .NUM_FU     (NFU),
        .NUM_VREGS  (32),
        .DEPTH      (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_execution_vector  (in_execution_vector),
        .in_vs2_addr          (in_vs2_addr),
        .in_vs1_addr          (in_vs1_addr),
        .in_vd_addr           (in_vd_addr),
        .in_v0_data           (in_v0_data),
        .in_vs2_data          (in_vs2_data),
        .in_vs1_data          (in_vs1_data),
        .in_vd_data           (in_vd_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_execution_vector (out_execution_vector),
        .out_v0               (out_v0),
        .out_vs2              (out_vs2),
        .out_vs1              (out_vs1),
        .out_vd               (out_vd),
        .out_bypass_hit       (out_bypass_hit),
        .wb_valid             (wb_valid),
        .wb_ready             (wb_ready),
        .wb_addr              (wb_addr),
        .wb_data              (wb_data),
        .rf_we                (rf_we),
        .rf_waddr             (rf_waddr),
        .rf_wdata             (rf_wdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wb(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid[port]            = 1'b1;
        wb_addr[port*AW +: AW]    = a;
        wb_data[port*DW +: DW]    = d;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_execution_vector = '0;
        in_vs2_addr = 5'd0; in_vs1_addr = 5'd3; in_vd_addr = 5'd4;
        in_v0_data = 64'h10; in_vs2_data = 64'h0; in_vs1_data = 64'h33; in_vd_data = 64'h44;
        wb_valid = '0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_hit", 64'(out_bypass_hit), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_wb_ready", 64'(wb_ready), 64'd0);

        // Plain issue, register-file data only.
        in_valid = 1'b1;
        in_vs2_addr = 5'd5; in_vs2_data = 64'hAA;
        in_execution_vector = '{funct6: 6'h2A, funct3: 3'h5, vsew: 3'h3, vm: 1'b1};
        tick();
        check("issue_out_valid", 64'(out_valid), 64'd1);
        check("issue_vs2", out_vs2, 64'hAA);
        check("issue_vs1", out_vs1, 64'h33);
        check("issue_v0", out_v0, 64'h10);
        check("issue_hit", 64'(out_bypass_hit), 64'd0);
        check("issue_exec", 64'(out_execution_vector), 64'({6'h2A, 3'h5, 3'h3, 1'b1}));
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // FU1 writes reg5; issue two cycles later picks it up from the buffer.
        set_wb(1, 5'd5, 64'h1234);
        #1;
        check("fu1_grant", 64'(wb_ready), 64'b0010);
        tick();
        wb_valid = '0;
        check("fu1_rf_we", 64'(rf_we), 64'd1);
        check("fu1_rf_waddr", 64'(rf_waddr), 64'd5);
        check("fu1_rf_wdata", rf_wdata, 64'h1234);
        tick();
        check("fu1_rf_we_drop", 64'(rf_we), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("buf_fwd_vs2", out_vs2, 64'h1234);
        check("buf_fwd_vs1", out_vs1, 64'h33);
        check("buf_fwd_hit", 64'(out_bypass_hit), 64'b0010);

        // Same-cycle forward: FU0 writes reg7 while vs1=7 is issued (pointer is at 2, wraps to 0).
        in_vs2_addr = 5'd2; in_vs1_addr = 5'd7; in_vs1_data = 64'h0;
        in_valid = 1'b1;
        set_wb(0, 5'd7, 64'h77);
        #1;
        check("fu0_wrap_grant", 64'(wb_ready), 64'b0001);
        tick();
        in_valid = 1'b0;
        wb_valid = '0;
        check("same_cycle_vs1", out_vs1, 64'h77);
        check("same_cycle_vs2", out_vs2, 64'hAA);
        check("same_cycle_hit", 64'(out_bypass_hit), 64'b0100);

        // Pointer is at 1; a lone FU3 write brings it back to 0.
        set_wb(3, 5'd9, 64'h99);
        #1;
        check("fu3_grant", 64'(wb_ready), 64'b1000);
        tick();
        wb_valid = '0;

        // All four ports request for four cycles: grants 0,1,2,3.
        for (int p = 0; p < NFU; p++) set_wb(p, AW'(10 + p), 64'(32'h100 + p));
        for (int c = 0; c < NFU; c++) begin
            #1;
            check($sformatf("rr_grant_%0d", c), 64'(wb_ready), 64'(4'b0001 << c));
            tick();
            check($sformatf("rr_waddr_%0d", c), 64'(rf_waddr), 64'(10 + c));
        end
        wb_valid = '0;

        // Five writes to regs 1..5 through FU0; reg1 is evicted from the 4-deep buffer.
        in_vs1_addr = 5'd21; in_vd_addr = 5'd20; in_vs1_data = 64'h33;
        for (int k = 1; k <= 5; k++) begin
            set_wb(0, AW'(k), 64'(32'h1000 + k));
            tick();
        end
        wb_valid = '0;
        in_valid = 1'b1;
        in_vs2_addr = 5'd1; in_vs2_data = 64'hAA;
        tick();
        check("evicted_vs2", out_vs2, 64'hAA);
        check("evicted_hit", 64'(out_bypass_hit), 64'b0000);
        in_vs2_addr = 5'd5;
        tick();
        check("newest_vs2", out_vs2, 64'h1005);
        check("newest_hit", 64'(out_bypass_hit), 64'b0010);

        // Stall: bundle held and not re-resolved even as a writeback lands.
        out_ready = 1'b0;
        in_vs2_addr = 5'd2;
        set_wb(0, 5'd5, 64'h5555);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_in_ready_%0d", c), 64'(in_ready), 64'd0);
            tick();
            wb_valid = '0;
            check($sformatf("stall_valid_%0d", c), 64'(out_valid), 64'd1);
            check($sformatf("stall_vs2_%0d", c), out_vs2, 64'h1005);
        end
        check("stall_wb_proceeds", 64'(rf_waddr), 64'd5);

        // Reset drops the held bundle and empties the buffer.
        reset = 1'b1;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        in_vs2_addr = 5'd5; in_vs2_data = 64'hAA;
        tick();
        in_valid = 1'b0;
        check("post_rst_vs2", out_vs2, 64'hAA);
        check("post_rst_hit", 64'(out_bypass_hit), 64'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
